seg7_scan: RTL and testbench
============================

Name: seg7_scan

Overview:
- Display stage downstream of the OSECPU core on the board top level.
- Captures the core's 32-bit data register value (dr) and shows one 16-bit half as four hex digits on a time-multiplexed common-anode 7-segment display.
- Drives `seg`/`segsel` directly.
- Inserts inter-digit blanking against ghosting; swaps the displayed value only at frame boundaries so a frame never tears.

Parameters:
- PRESCALE, 50000, clk cycles each digit is lit (1 kHz digit rate at 50 MHz); legal ≥ 2.
- BLANK_CYCLES, 500, clk cycles all digits are off between digits; legal ≥ 1.
- SEG_ACTIVE_LOW, 1, 1 = segment lines active-low.
- SEL_ACTIVE_LOW, 1, 1 = digit-select lines active-low.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- data  in  32  value to display (OSECPU dr)
- update  in  1  1 = capture `data` into the pending register this cycle
- half_sel  in  1  0 = show data[15:0], 1 = show data[31:16]
- seg  out  8  {dp,g,f,e,d,c,b,a}
- segsel  out  4  digit enables; bit 0 = rightmost digit = least-significant nibble
- frame_start  out  1  one-cycle pulse on the BLANK→SHOW transition for digit 0

Behaviour:
- Registers:
  - `pending[31:0]`: loaded from `data` whenever update=1.
  - `shown[31:0]` and `shown_half`: loaded from `pending` and half_sel only at frame start.
- State machine: BLANK, SHOW. Also kept: down-counter `cnt` and 2-bit `digit`.
- On reset (synchronous, wins over everything):
  - state = BLANK, cnt = BLANK_CYCLES-1, digit = 3.
  - pending = 0, shown = 0, shown_half = 0.
  - All outputs inactive: seg = 8'hFF and segsel = 4'hF with default polarities; frame_start = 0.
- BLANK:
  - segsel all inactive, seg all inactive.
  - When cnt == 0: go to SHOW, digit ← digit+1 (mod 4, 3 wraps to 0), cnt ← PRESCALE-1.
  - If the new digit is 0, the same edge does shown ← pending, shown_half ← half_sel, and asserts frame_start for that first SHOW cycle.
- SHOW:
  - segsel has only bit `digit` active.
  - seg = hex pattern of nibble `digit` of the selected half of `shown`.
  - dp is active only when digit == 0 and shown_half == 1; otherwise dp is inactive.
  - When cnt == 0: go to BLANK, cnt ← BLANK_CYCLES-1.
- All outputs are registered; no combinational path from inputs to outputs.
- Timing after reset:
  - First reset-free cycle is BLANK, then BLANK_CYCLES cycles of blanking.
  - Digit 0 is lit on cycle BLANK_CYCLES (counting from 0) for PRESCALE cycles.
  - One frame = 4×(PRESCALE+BLANK_CYCLES) cycles.
- Hex patterns (active-high gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Inverted when SEG_ACTIVE_LOW = 1.
- Simultaneous update and frame start: `shown` takes the old `pending`; the new data appears at the next frame.
- Multiple updates within a frame: the last one wins.
- half_sel changes mid-frame: no effect until the next frame start.
- Reset asserted mid-SHOW: outputs go inactive on the next edge; scanning restarts as after power-up.

Test Plan:
- Reset check (PRESCALE=4, BLANK_CYCLES=1): hold reset 3 cycles, then release.
  - seg=FF, segsel=F during reset.
  - Cycle 0 after release blank; cycles 1–4 digit 0 lit with segsel=1110 and seg=C0 (pattern "0", pending=0); frame_start=1 on cycle 1 only.
- Core result: update=1 with data=32'hFFFFFFFC (−4), half_sel=0; observe the following frame.
  - Digit 0: segsel=1110, seg=C6 ("C").
  - Digits 1–3: segsel=1101/1011/0111, seg=8E ("F").
  - One blank cycle with segsel=F between digits.
- Upper half: half_sel=1 with the same data.
  - Next frame digit 0 shows seg=0E ("F" with dp lit).
  - All digits show "F" pattern.
- Tear-free update: pulse update with 32'h00001234 while digit 2 is lit.
  - Rest of the frame still shows FFFC.
  - Next frame shows "4","3","2","1" = 99, B0, A4, F9 on digits 0–3.
- Same-cycle collision: assert update with 32'h0000000A exactly on the frame_start edge.
  - That frame shows the previous value.
  - The following frame shows digit 0 = 88 ("A").
- Mid-scan reset: assert reset during digit 3 SHOW.
  - Next edge: seg=FF, segsel=F.
  - After release, the timing of the reset-check scenario repeats exactly and displays 0000.

Source files
------------

// File: rtl/seg7_scan.sv
// Four-digit time-multiplexed 7-segment scanner with inter-digit blanking.
// The displayed word is latched only at frame start so a frame never tears.
module seg7_scan #(
  parameter int unsigned PRESCALE       = 50000,
  parameter int unsigned BLANK_CYCLES   = 500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic        update,
  input  logic        half_sel,
  output logic [7:0]  seg,
  output logic [3:0]  segsel,
  output logic        frame_start
);

  localparam int unsigned CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] PRE_LOAD   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [7:0]       SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0]       SEL_OFF    = SEL_ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic {StBlank, StShow} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       digit;
  logic [31:0]      pending;
  logic [31:0]      shown;
  logic             shown_half;

  logic [1:0]  digit_nxt;
  logic [31:0] src_word;
  logic        src_half;
  logic [15:0] src_16;
  logic [3:0]  nib;
  logic [7:0]  seg_act;
  logic [7:0]  seg_pat;
  logic [3:0]  sel_pat;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    unique case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Pattern for the digit about to be lit; digit 0 sources the word being latched this edge.
  always_comb begin
    digit_nxt = digit + 2'd1;
    src_word  = (digit_nxt == 2'd0) ? pending : shown;
    src_half  = (digit_nxt == 2'd0) ? half_sel : shown_half;
    src_16    = src_half ? src_word[31:16] : src_word[15:0];
    nib       = src_16[{digit_nxt, 2'b00} +: 4];
    seg_act   = {(digit_nxt == 2'd0) && src_half, hex7(nib)};
    seg_pat   = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
    sel_pat   = SEL_ACTIVE_LOW ? ~(4'b0001 << digit_nxt) : (4'b0001 << digit_nxt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StBlank;
      cnt         <= BLANK_LOAD;
      digit       <= 2'd3;
      pending     <= '0;
      shown       <= '0;
      shown_half  <= 1'b0;
      seg         <= SEG_OFF;
      segsel      <= SEL_OFF;
      frame_start <= 1'b0;
    end else begin
      if (update) pending <= data;
      frame_start <= 1'b0;
      unique case (state)
        StBlank: begin
          if (cnt == '0) begin
            state  <= StShow;
            cnt    <= PRE_LOAD;
            digit  <= digit_nxt;
            seg    <= seg_pat;
            segsel <= sel_pat;
            if (digit_nxt == 2'd0) begin
              shown       <= pending;
              shown_half  <= half_sel;
              frame_start <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StShow: begin
          if (cnt == '0) begin
            state  <= StBlank;
            cnt    <= BLANK_LOAD;
            seg    <= SEG_OFF;
            segsel <= SEL_OFF;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= StBlank;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with PRESCALE=4, BLANK_CYCLES=1 (20-cycle frames).
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data;
  logic        update;
  logic        half_sel;
  logic [7:0]  seg;
  logic [3:0]  segsel;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan #(
    .PRESCALE      (4),
    .BLANK_CYCLES  (1),
    .SEG_ACTIVE_LOW(1'b1),
    .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .update     (update),
    .half_sel   (half_sel),
    .seg        (seg),
    .segsel     (segsel),
    .frame_start(frame_start)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_off(input string tag);
    check_eq($sformatf("%s seg", tag), {24'b0, seg}, 32'hFF);
    check_eq($sformatf("%s segsel", tag), {28'b0, segsel}, 32'hF);
    check_eq($sformatf("%s fs", tag), {31'b0, frame_start}, 32'h0);
  endtask

  // Walks n cycles of a frame starting at its first lit cycle; optionally pulses update
  // during cycle index upd_at (index 19 lands on the next frame-start edge).
  task automatic run_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input int upd_at,
                           input logic [31:0] upd_data, input int n);
    logic [7:0] exp_seg [4];
    logic [3:0] exp_sel [4];
    int d;
    int p;
    exp_seg = '{e0, e1, e2, e3};
    exp_sel = '{4'hE, 4'hD, 4'hB, 4'h7};
    for (int i = 0; i < n; i++) begin
      d = i / 5;
      p = i % 5;
      if (p < 4) begin
        check_eq($sformatf("%s d%0d c%0d segsel", tag, d, p), {28'b0, segsel}, {28'b0, exp_sel[d]});
        check_eq($sformatf("%s d%0d c%0d seg", tag, d, p), {24'b0, seg}, {24'b0, exp_seg[d]});
        check_eq($sformatf("%s d%0d c%0d fs", tag, d, p), {31'b0, frame_start},
                 (i == 0) ? 32'h1 : 32'h0);
      end else begin
        check_off($sformatf("%s blank%0d", tag, d));
      end
      update = (i == upd_at);
      if (i == upd_at) data = upd_data;
      @(negedge clk);
    end
    update = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    update   = 1'b0;
    half_sel = 1'b0;
    data     = '0;
    repeat (3) begin
      @(negedge clk);
      check_off("in_reset");
    end
    reset = 1'b0;
    check_off("cycle0");
    @(negedge clk);
    run_frame("reset", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 4, 32'hFFFF_FFFC, 20);
    // half_sel changes now but only takes effect at the next frame start.
    half_sel = 1'b1;
    run_frame("core", 8'hC6, 8'h8E, 8'h8E, 8'h8E, -1, 32'h0, 20);
    half_sel = 1'b0;
    run_frame("upper", 8'h0E, 8'h8E, 8'h8E, 8'h8E, -1, 32'h0, 20);
    run_frame("tear", 8'hC6, 8'h8E, 8'h8E, 8'h8E, 11, 32'h0000_1234, 20);
    run_frame("newval", 8'h99, 8'hB0, 8'hA4, 8'hF9, 19, 32'h0000_000A, 20);
    run_frame("collide", 8'h99, 8'hB0, 8'hA4, 8'hF9, -1, 32'h0, 20);
    run_frame("after", 8'h88, 8'hC0, 8'hC0, 8'hC0, -1, 32'h0, 17);
    // Now mid digit-3 SHOW.
    reset = 1'b1;
    @(negedge clk);
    check_off("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_off("re_cycle0");
    @(negedge clk);
    run_frame("restart", 8'hC0, 8'hC0, 8'hC0, 8'hC0, -1, 32'h0, 20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
